// File: rtl/aes_dec_iter_pkg.sv
// Shared definitions for the iterative AES inverse-cipher engine.
// Contents:
//   state_e    - engine FSM state encoding
//   nr_legal   - round-count legality check (10, 12 or 14)
//   xtime/gmul - GF(2^8) helpers used by InvMixColumns
//   gf_inv     - GF(2^8) multiplicative inverse (0 maps to 0)
//   inv_sbox   - inverse S-box lookup function
package aes_dec_iter_pkg;

    localparam int unsigned BlockW = 128;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StFinal = 2'd2,
        StDone  = 2'd3
    } state_e;

    function automatic bit nr_legal(input int unsigned nr);
        return (nr == 10) || (nr == 12) || (nr == 14);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); square-and-multiply over the seven set bits of 254.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine transform, then take the field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] x;
        x = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(x);
    endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// Block stream + key-store bundle for aes_dec_iter.
//   din/in_valid/in_ready    - ciphertext input handshake (byte 0 in [127:120])
//   rkey_idx/rkey            - round-key index out, same-cycle key back
//   dout/out_valid/out_ready - plaintext output handshake
// slave: engine side. master: source, sink and key store side.
interface aes_dec_iter_if;
    logic [127:0] din;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   rkey_idx;
    logic [127:0] rkey;
    logic [127:0] dout;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  din, in_valid, rkey, out_ready,
        output in_ready, rkey_idx, dout, out_valid
    );

    modport master (
        output din, in_valid, rkey, out_ready,
        input  in_ready, rkey_idx, dout, out_valid
    );
endinterface

// File: rtl/aes_dec_iter_inv_round.sv
// One AES inverse round, purely combinational.
//   din    - round input state
//   rkey   - round key
//   mix_en - apply InvMixColumns (low on the first iteration)
//   dout   - InvSubBytes(InvShiftRows(InvMixColumns?(din ^ rkey)))
module aes_dec_iter_inv_round
    import aes_dec_iter_pkg::*;
(
    input  logic [127:0] din,
    input  logic [127:0] rkey,
    input  logic         mix_en,
    output logic [127:0] dout
);

    logic [127:0] ark;
    logic [127:0] mix;
    logic [7:0]   a0, a1, a2, a3;

    always_comb begin
        ark = din ^ rkey;
        mix = ark;
        a0  = 8'h00;
        a1  = 8'h00;
        a2  = 8'h00;
        a3  = 8'h00;
        if (mix_en) begin
            for (int c = 0; c < 4; c++) begin
                a0 = ark[127 - 32*c -: 8];
                a1 = ark[119 - 32*c -: 8];
                a2 = ark[111 - 32*c -: 8];
                a3 = ark[103 - 32*c -: 8];
                mix[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                                     ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                mix[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                                     ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                mix[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                                     ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                mix[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                                     ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
    end

    // Byte k sits at row k%4, column k/4. Row r rotates right by r columns,
    // so output (r,c) takes input (r,(c-r) mod 4); S-box is applied on the way.
    always_comb begin
        dout = '0;
        for (int k = 0; k < 16; k++) begin
            dout[127 - 8*k -: 8] =
                inv_sbox(mix[127 - 8*((((k / 4) + 4 - (k % 4)) % 4) * 4 + (k % 4)) -: 8]);
        end
    end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES inverse cipher: one shared round per clock, NR+1 cycles from
// acceptance to out_valid. Round keys are fetched by index from an external store.
//   NR  - rounds (10/12/14 for AES-128/192/256)
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - stream handshakes and key-store port (aes_dec_iter_if.slave)
module aes_dec_iter
    import aes_dec_iter_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input logic          clk,
    input logic          rst,
    aes_dec_iter_if.slave bus
);

    if (!nr_legal(NR)) begin : g_nr_check
        $error("aes_dec_iter: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NrIdx  = 4'(NR);
    localparam logic [3:0] NrLast = 4'(NR - 1);

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] dout_q, dout_d;
    logic         out_valid_q, out_valid_d;

    logic         in_ready;
    logic [3:0]   rkey_idx;
    logic [127:0] round_out;

    aes_dec_iter_inv_round u_round (
        .din    (st_q),
        .rkey   (bus.rkey),
        .mix_en (rnd_q != 4'd0),
        .dout   (round_out)
    );

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        rkey_idx    = 4'd0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    st_d    = bus.din;
                    rnd_d   = 4'd0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Keys are consumed last-to-first.
                rkey_idx = NrIdx - rnd_q;
                st_d     = round_out;
                rnd_d    = rnd_q + 4'd1;
                if (rnd_q == NrLast) state_d = StFinal;
            end
            StFinal: begin
                rkey_idx    = 4'd0;
                dout_d      = st_q ^ bus.rkey;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                // Freeing the output slot also frees the input, allowing a
                // same-cycle consume and accept.
                in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.in_valid) begin
                        st_d    = bus.din;
                        rnd_d   = 4'd0;
                        state_d = StBusy;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rnd_q       <= 4'd0;
            st_q        <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.rkey_idx  = rkey_idx;
    assign bus.dout      = dout_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter with FIPS-197 vectors for AES-128/192/256.
// Each engine is backed by a round-key store filled by a local key expansion.
module tb_aes_dec_iter;

    localparam logic [127:0] Pt    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Ct192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] Ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] Key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] Key192 =
        {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] Key256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_dec_iter_if ifc10 ();
    aes_dec_iter_if ifc12 ();
    aes_dec_iter_if ifc14 ();

    aes_dec_iter #(.NR(10)) u_dut10 (.clk(clk), .rst(rst), .bus(ifc10));
    aes_dec_iter #(.NR(12)) u_dut12 (.clk(clk), .rst(rst), .bus(ifc12));
    aes_dec_iter #(.NR(14)) u_dut14 (.clk(clk), .rst(rst), .bus(ifc14));

    logic [127:0] rk10 [0:15];
    logic [127:0] rk12 [0:15];
    logic [127:0] rk14 [0:15];
    logic [31:0]  w    [0:59];

    assign ifc10.rkey = rk10[ifc10.rkey_idx];
    assign ifc12.rkey = rk12[ifc12.rkey_idx];
    assign ifc14.rkey = rk14[ifc14.rkey_idx];

    int n_assert;
    int n_fail;
    int lat10, lat12, lat14, n_out;
    logic [127:0] cap12, cap14, cap10;

    function automatic logic [7:0] tb_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = tb_xtime(aa);
        end
        return p;
    endfunction

    // Forward S-box for the key schedule: field inverse then affine map.
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] b;
        p = x;
        b = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = tb_mul(p, p);
            b = tb_mul(b, p);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {tb_sbox(v[31:24]), tb_sbox(v[23:16]), tb_sbox(v[15:8]), tb_sbox(v[7:0])};
    endfunction

    task automatic expand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = tb_xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int r = 0; r < 16; r++) begin
            rk10[r] = '0;
            rk12[r] = '0;
            rk14[r] = '0;
        end
        expand(4, Key128);
        for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        expand(6, Key192);
        for (int r = 0; r <= 12; r++) rk12[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        expand(8, Key256);
        for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        rst = 1'b1;
        ifc10.din = '0; ifc10.in_valid = 1'b0; ifc10.out_ready = 1'b0;
        ifc12.din = '0; ifc12.in_valid = 1'b0; ifc12.out_ready = 1'b1;
        ifc14.din = '0; ifc14.in_valid = 1'b0; ifc14.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_in_ready10", 128'(ifc10.in_ready), 128'd1);
        check("rst_out_valid10", 128'(ifc10.out_valid), 128'd0);
        check("rst_dout10", ifc10.dout, 128'd0);
        check("rst_rkey_idx10", 128'(ifc10.rkey_idx), 128'd0);
        check("rst_out_valid12", 128'(ifc12.out_valid), 128'd0);
        check("rst_out_valid14", 128'(ifc14.out_valid), 128'd0);

        // All three key lengths start together; engine 10 keeps in_valid high
        // and out_ready low so it also runs into sustained backpressure.
        ifc10.din = Ct128; ifc10.in_valid = 1'b1;
        ifc12.din = Ct192; ifc12.in_valid = 1'b1;
        ifc14.din = Ct256; ifc14.in_valid = 1'b1;
        #1;
        check("acc_in_ready10", 128'(ifc10.in_ready), 128'd1);
        check("acc_in_ready12", 128'(ifc12.in_ready), 128'd1);
        check("acc_in_ready14", 128'(ifc14.in_ready), 128'd1);
        @(negedge clk);
        ifc12.in_valid = 1'b0;
        ifc14.in_valid = 1'b0;
        lat10 = -1; lat12 = -1; lat14 = -1;
        cap12 = '0; cap14 = '0;
        for (int cnt = 0; cnt < 32; cnt++) begin
            if (cnt > 0) @(negedge clk);
            if (cnt <= 10) begin
                check($sformatf("rkey_idx10_c%0d", cnt), 128'(ifc10.rkey_idx),
                      128'((cnt < 10) ? 10 - cnt : 0));
                check($sformatf("busy_in_ready10_c%0d", cnt), 128'(ifc10.in_ready), 128'd0);
            end
            if (ifc10.out_valid && lat10 < 0) lat10 = cnt;
            if (ifc12.out_valid && lat12 < 0) begin lat12 = cnt; cap12 = ifc12.dout; end
            if (ifc14.out_valid && lat14 < 0) begin lat14 = cnt; cap14 = ifc14.dout; end
            if (cnt >= 11) begin
                check($sformatf("hold_out_valid10_c%0d", cnt), 128'(ifc10.out_valid), 128'd1);
                check($sformatf("hold_dout10_c%0d", cnt), ifc10.dout, Pt);
                check($sformatf("hold_in_ready10_c%0d", cnt), 128'(ifc10.in_ready), 128'd0);
            end
        end
        check("latency10", 128'(lat10), 128'd11);
        check("latency12", 128'(lat12), 128'd13);
        check("latency14", 128'(lat14), 128'd15);
        check("dout12", cap12, Pt);
        check("dout14", cap14, Pt);

        // Release with in_valid still high: consume and accept on one edge.
        ifc10.out_ready = 1'b1;
        #1;
        check("pulse_in_ready10", 128'(ifc10.in_ready), 128'd1);
        @(negedge clk);
        ifc10.out_ready = 1'b0;
        check("consumed_once10", 128'(ifc10.out_valid), 128'd0);
        check("b2_rkey_idx10_c0", 128'(ifc10.rkey_idx), 128'd10);
        for (int cnt = 1; cnt <= 5; cnt++) begin
            @(negedge clk);
            check($sformatf("b2_out_valid10_c%0d", cnt), 128'(ifc10.out_valid), 128'd0);
            check($sformatf("b2_rkey_idx10_c%0d", cnt), 128'(ifc10.rkey_idx), 128'(10 - cnt));
        end

        // Reset at rnd=5 discards the in-flight block.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifc10.in_valid = 1'b0;
        check("mid_rst_in_ready10", 128'(ifc10.in_ready), 128'd1);
        check("mid_rst_out_valid10", 128'(ifc10.out_valid), 128'd0);
        check("mid_rst_dout10", ifc10.dout, 128'd0);
        check("mid_rst_rkey_idx10", 128'(ifc10.rkey_idx), 128'd0);

        // Fresh block after reset, sink always ready.
        ifc10.din       = Ct128;
        ifc10.in_valid  = 1'b1;
        ifc10.out_ready = 1'b1;
        @(negedge clk);
        ifc10.in_valid = 1'b0;
        lat10 = -1;
        n_out = 0;
        cap10 = '0;
        for (int cnt = 0; cnt < 20; cnt++) begin
            if (cnt > 0) @(negedge clk);
            if (ifc10.out_valid) begin
                n_out++;
                if (lat10 < 0) begin lat10 = cnt; cap10 = ifc10.dout; end
            end
        end
        check("fresh_latency10", 128'(lat10), 128'd11);
        check("fresh_dout10", cap10, Pt);
        check("fresh_out_count10", 128'(n_out), 128'd1);
        check("fresh_idle_in_ready10", 128'(ifc10.in_ready), 128'd1);
        check("fresh_idle_out_valid10", 128'(ifc10.out_valid), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
